// File: rtl/uart_rx_core_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types and helpers for the UART receive path:
//                receiver state encoding, bit-period calculation, data width.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } rx_state_e;

    // Number of system clocks per serial bit (integer divide).
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_rx_core_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_core_if
//  Description : Serial line plus received-byte strobes of the UART receiver.
//                parity_err exists only when UART_RX_PARITY_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_core_if;

    logic       serial_in;
    logic       full;
    logic [7:0] parallel_out;
    logic       frame_err;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    // Receiver core side
    modport slave (
        input  serial_in,
        output full,
        output parallel_out,
`ifdef UART_RX_PARITY_EN
        output parity_err,
`endif
        output frame_err
    );

    // Line driver / byte consumer side
    modport master (
        output serial_in,
        input  full,
        input  parallel_out,
`ifdef UART_RX_PARITY_EN
        input  parity_err,
`endif
        input  frame_err
    );

endinterface : uart_rx_core_if
`default_nettype wire

// File: rtl/uart_rx_core_sync2.sv
`default_nettype none
// ============================================================================
//  Module      : sync2
//  Description : Two-flop synchronizer for a single asynchronous bit with a
//                configurable reset value (idle-high lines reset to 1).
//  Revision    : 1.0 - initial release
// ============================================================================
module sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic d_i,
    output logic      q_o
);

    logic meta_q;
    logic sync_q;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule : sync2
`default_nettype wire

// File: rtl/uart_rx_core.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_core
//  Description : Oversampling UART receiver, 8 data bits LSB first, 1 stop
//                bit. Each good byte is presented on parallel_out with a
//                one-cycle full strobe; a low stop bit gives a one-cycle
//                frame_err and the byte is discarded.
//                Define UART_RX_PARITY_EN for an even-parity bit after bit 7
//                and a parity_err strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD_RATE = 115200
) (
    input  wire logic       clk,
    input  wire logic       reset,
    uart_rx_core_if.slave   bus
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int TIMER_W      = $clog2(CLKS_PER_BIT);
    // Start bit is re-checked half a bit in; every later sample is one bit on.
    localparam logic [TIMER_W-1:0] HALF_RELOAD = TIMER_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TIMER_W-1:0] BIT_RELOAD  = TIMER_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]         LAST_BIT    = 3'(DATA_BITS - 1);

    logic                 rxs;
    rx_state_e            state_q,  state_d;
    logic [TIMER_W-1:0]   timer_q,  timer_d;
    logic [2:0]           bitcnt_q, bitcnt_d;
    logic [DATA_BITS-1:0] shift_q,  shift_d;
    logic [DATA_BITS-1:0] dout_q,   dout_d;
    logic                 full_q,   full_d;
    logic                 ferr_q,   ferr_d;
`ifdef UART_RX_PARITY_EN
    logic                 par_q,    par_d;
    logic                 perr_q,   perr_d;
`endif
    logic                 expired;

    sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (bus.serial_in),
        .q_o   (rxs)
    );

    assign expired = (timer_q == '0);

    // State, timer, shift register and strobe registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            bitcnt_q <= '0;
            shift_q  <= '0;
            dout_q   <= '0;
            full_q   <= 1'b0;
            ferr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q    <= 1'b0;
            perr_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            dout_q   <= dout_d;
            full_q   <= full_d;
            ferr_q   <= ferr_d;
`ifdef UART_RX_PARITY_EN
            par_q    <= par_d;
            perr_q   <= perr_d;
`endif
        end
    end

    // Frame sequencing: next state, sampling and strobe generation.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        dout_d   = dout_q;
        full_d   = 1'b0;
        ferr_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d    = par_q;
        perr_d   = 1'b0;
`endif
        if (state_q != IDLE && state_q != BREAK && !expired) begin
            timer_d = timer_q - TIMER_W'(1);
        end
        case (state_q)
            IDLE: begin
                if (!rxs) begin
                    state_d = START;
                    timer_d = HALF_RELOAD;
                end
            end
            START: begin
                if (expired) begin
                    if (rxs) begin
                        // Line went back high before mid-start: a glitch.
                        state_d = IDLE;
                    end else begin
                        state_d  = DATA;
                        timer_d  = BIT_RELOAD;
                        bitcnt_d = '0;
                    end
                end
            end
            DATA: begin
                if (expired) begin
                    shift_d[bitcnt_q] = rxs;
                    timer_d           = BIT_RELOAD;
                    if (bitcnt_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bitcnt_d = bitcnt_q + 3'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (expired) begin
                    par_d   = rxs;
                    timer_d = BIT_RELOAD;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (expired) begin
                    if (rxs) begin
                        state_d = IDLE;
`ifdef UART_RX_PARITY_EN
                        if (par_q != ^shift_q) begin
                            perr_d = 1'b1;
                        end else begin
                            dout_d = shift_q;
                            full_d = 1'b1;
                        end
`else
                        dout_d = shift_q;
                        full_d = 1'b1;
`endif
                    end else begin
                        // Frame error wins over parity; wait out any break.
                        ferr_d  = 1'b1;
                        state_d = BREAK;
                    end
                end
            end
            BREAK: begin
                if (rxs) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.full         = full_q;
    assign bus.frame_err    = ferr_q;
    assign bus.parallel_out = dout_q;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err   = perr_q;
`endif

endmodule : uart_rx_core
`default_nettype wire
